tx_sym_fir_cfg: RTL and testbench

//  Parametrised, fully pipelined symmetric (linear-phase) FIR for the TX pulse-shaping path.

---
 rtl/tx_sym_fir_cfg.sv | 149 ++++++++++++++
 tb/tb_tx_sym_fir_cfg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tx_sym_fir_cfg.sv
`default_nettype none
// ============================================================================
// Module : tx_sym_fir_cfg
// Symmetric odd-length FIR with shadow/active coefficient banks, a registered
// adder tree, and round-half-up / saturating output with sticky overflow flag.
// Rev    : 1.0
// ============================================================================
module tx_sym_fir_cfg #(
  parameter  int NTAPS     = 21,
  parameter  int DW        = 18,
  parameter  int CW        = 18,
  parameter  int COEF_FRAC = 17,
  localparam int NUNIQ     = (NTAPS + 1) / 2,
  localparam int AW        = $clog2(NUNIQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_wr,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic                 swap_pend,
  output logic signed [DW-1:0] y,
  output logic                 y_valid,
  output logic                 sat_flag
);
  localparam int T   = $clog2(NUNIQ);
  localparam int LAT = 3 + T;
  localparam int PW  = DW + 1;
  localparam int MW  = PW + CW;
  localparam int SW  = MW + T;
  localparam int CTR = NUNIQ - 1;

  localparam logic signed [CW-1:0] C_UNITY = CW'((1 << COEF_FRAC) - 1);
  localparam logic signed [SW-1:0] C_HALF  = SW'(1) << (COEF_FRAC - 1);
  localparam logic signed [DW-1:0] C_YMAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] C_YMIN  = {1'b1, {(DW-1){1'b0}}};

  function automatic int nodes(input int lvl);
    return (NUNIQ + (1 << lvl) - 1) >> lvl;
  endfunction

  logic signed [CW-1:0] shadow [NUNIQ];
  logic signed [CW-1:0] active [NUNIQ];
  logic signed [CW-1:0] mbank  [NUNIQ];
  logic signed [DW-1:0] xdl    [NTAPS];
  logic signed [PW-1:0] pre    [NUNIQ];
  logic signed [SW-1:0] tree   [T+1][NUNIQ];
  logic [LAT-1:0]       vpipe;
  logic                 commit;
  logic signed [SW-1:0] rnd;
  logic signed [SW-1:0] shf;
  logic                 ovf;
  logic signed [DW-1:0] ysat;

  assign commit = sample_en && (swap_pend || coef_swap);

  // mbank lags active by one clock so the commit sample is the first to
  // reach the multiplier with the new bank while older samples keep the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      swap_pend <= 1'b0;
      for (int i = 0; i < NUNIQ; i++) begin
        shadow[i] <= (i == CTR) ? C_UNITY : '0;
        active[i] <= (i == CTR) ? C_UNITY : '0;
        mbank[i]  <= (i == CTR) ? C_UNITY : '0;
      end
    end else begin
      if (coef_wr && (int'(coef_addr) < NUNIQ))
        shadow[coef_addr] <= coef_data;
      if (commit) begin
        active    <= shadow;
        swap_pend <= 1'b0;
      end else if (coef_swap) begin
        swap_pend <= 1'b1;
      end
      mbank <= active;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) xdl[i] <= '0;
      for (int i = 0; i < NUNIQ; i++) pre[i] <= '0;
    end else begin
      if (sample_en) begin
        xdl[0] <= x_in;
        for (int i = 1; i < NTAPS; i++) xdl[i] <= xdl[i-1];
      end
      for (int i = 0; i < CTR; i++)
        pre[i] <= {xdl[i][DW-1], xdl[i]} + {xdl[NTAPS-1-i][DW-1], xdl[NTAPS-1-i]};
      pre[CTR] <= {xdl[CTR][DW-1], xdl[CTR]};
    end
  end

  for (genvar i = 0; i < NUNIQ; i++) begin : g_mul
    always_ff @(posedge clk) begin
      if (reset) tree[0][i] <= '0;
      else       tree[0][i] <= SW'($signed({{CW{pre[i][PW-1]}}, pre[i]}) *
                                   $signed({{PW{mbank[i][CW-1]}}, mbank[i]}));
    end
  end

  for (genvar l = 1; l <= T; l++) begin : g_lvl
    localparam int NP = nodes(l - 1);
    for (genvar j = 0; j < NUNIQ; j++) begin : g_node
      if (2*j + 1 < NP) begin : g_add
        always_ff @(posedge clk) begin
          if (reset) tree[l][j] <= '0;
          else       tree[l][j] <= tree[l-1][2*j] + tree[l-1][2*j+1];
        end
      end else if (2*j < NP) begin : g_pass
        always_ff @(posedge clk) begin
          if (reset) tree[l][j] <= '0;
          else       tree[l][j] <= tree[l-1][2*j];
        end
      end else begin : g_zero
        always_ff @(posedge clk) tree[l][j] <= '0;
      end
    end
  end

  always_comb begin
    rnd  = tree[T][0] + C_HALF;
    shf  = rnd >>> COEF_FRAC;
    ovf  = !((&shf[SW-1:DW-1]) || !(|shf[SW-1:DW-1]));
    ysat = ovf ? (shf[SW-1] ? C_YMIN : C_YMAX) : shf[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe    <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      vpipe   <= {vpipe[LAT-2:0], sample_en};
      y_valid <= vpipe[LAT-1];
      if (vpipe[LAT-1]) begin
        y <= ysat;
        if (ovf) sat_flag <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_sym_fir_cfg.sv
`default_nettype none
// Directed bench for tx_sym_fir_cfg: impulse, coefficient swap, strobe spacing,
// saturation and mid-stream reset, with hand-computed expected outputs.
module tb_tx_sym_fir_cfg;
  localparam int DW = 18;
  localparam int CW = 18;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sample_en;
  logic signed [DW-1:0] x_in;
  logic                 coef_wr;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_swap;
  logic                 swap_pend;
  logic signed [DW-1:0] y;
  logic                 y_valid;
  logic                 sat_flag;

  int errors = 0;
  int checks = 0;
  logic signed [DW-1:0] outq [$];

  tx_sym_fir_cfg dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .x_in(x_in),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_swap(coef_swap), .swap_pend(swap_pend), .y(y),
    .y_valid(y_valid), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (y_valid === 1'b1) outq.push_back(y);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] get(input int i);
    if (i < outq.size()) return 32'(outq[i]);
    return 32'sh7fff_ffff;
  endfunction

  task automatic stream(input int n, input int xv);
    for (int k = 0; k < n; k++) begin
      sample_en = 1'b1;
      x_in      = DW'(xv);
      tick();
    end
    sample_en = 1'b0;
  endtask

  task automatic drain();
    sample_en = 1'b0;
    repeat (10) tick();
  endtask

  task automatic wr(input int a, input int d);
    coef_wr   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    tick();
    coef_wr   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; x_in = '0; coef_wr = 1'b0;
    coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_swap_pend", swap_pend, 0);

    // Impulse through the default bank
    outq.delete();
    for (int s = 0; s < 25; s++) begin
      sample_en = 1'b1;
      x_in      = (s == 0) ? 18'sd65536 : 18'sd0;
      tick();
      if (s == 6) check("imp_lat_before", y_valid, 0);
      if (s == 7) check("imp_lat_first", y_valid, 1);
    end
    drain();
    check("imp_count", outq.size(), 25);
    check("imp_centre", get(10), 65536);
    begin
      int nz = 0;
      for (int i = 0; i < 25; i++) if (i != 10 && get(i) != 0) nz++;
      check("imp_others_zero", nz, 0);
    end

    // Flat bank of 8192, swap requested while idle
    for (int a = 0; a < 11; a++) wr(a, 8192);
    coef_swap = 1'b1; tick(); coef_swap = 1'b0;
    check("flat_pend_set", swap_pend, 1);
    tick();
    check("flat_pend_hold", swap_pend, 1);
    outq.delete();
    stream(1, 1000);
    check("flat_pend_clear", swap_pend, 0);
    stream(29, 1000);
    drain();
    check("flat_count", outq.size(), 30);
    check("flat_first", get(0), 63);
    check("flat_half", get(10), 688);
    check("flat_steady", get(29), 1313);
    check("flat_no_sat", sat_flag, 0);

    // Swap coherence on a step input: flat bank -> impulse bank
    for (int a = 0; a < 10; a++) wr(a, 0);
    wr(10, 131071);
    outq.delete();
    stream(5, 1000);
    coef_swap = 1'b1; tick(); coef_swap = 1'b0;
    check("swp_pend_set", swap_pend, 1);
    stream(1, 2000);
    check("swp_pend_clear", swap_pend, 0);
    stream(14, 2000);
    drain();
    check("swp_count", outq.size(), 20);
    check("swp_last_old", get(4), 1313);
    check("swp_commit", get(5), 1000);
    check("swp_pre_step", get(14), 1000);
    check("swp_step", get(15), 2000);

    // Strobe every 4th cycle; swap request between strobes
    outq.delete();
    for (int s = 0; s < 40; s++) begin
      sample_en = (s % 4 == 0);
      x_in      = 18'sd3000;
      coef_swap = (s == 13);
      tick();
      coef_swap = 1'b0;
      if (s >= 7 && s <= 14) check($sformatf("sparse_valid_%0d", s), y_valid, ((s - 7) % 4 == 0) ? 1 : 0);
      if (s == 13) check("sparse_pend_set", swap_pend, 1);
      if (s == 15) check("sparse_pend_hold", swap_pend, 1);
      if (s == 16) check("sparse_pend_clear", swap_pend, 0);
    end
    check("sparse_y_hold", y, 2000);
    drain();
    check("sparse_count", outq.size(), 10);

    // Saturation both ways; swap committed on the same edge as coef_swap
    for (int a = 0; a < 11; a++) wr(a, 131071);
    coef_swap = 1'b1;
    stream(1, 131071);
    coef_swap = 1'b0;
    check("sat_pend_direct", swap_pend, 0);
    stream(29, 131071);
    drain();
    check("sat_pos_y", y, 131071);
    check("sat_pos_flag", sat_flag, 1);
    stream(30, -131072);
    drain();
    check("sat_neg_y", y, -131072);
    check("sat_neg_flag", sat_flag, 1);

    // Reset mid-stream with writes/swap attempted during reset
    stream(5, 7);
    reset = 1'b1; sample_en = 1'b1; coef_swap = 1'b1;
    coef_wr = 1'b1; coef_addr = 4'd10; coef_data = '0;
    tick();
    reset = 1'b0; sample_en = 1'b0; coef_swap = 1'b0; coef_wr = 1'b0;
    outq.delete();
    check("mrst_y", y, 0);
    check("mrst_y_valid", y_valid, 0);
    check("mrst_sat_flag", sat_flag, 0);
    check("mrst_swap_pend", swap_pend, 0);
    for (int s = 0; s < 20; s++) begin
      sample_en = 1'b1;
      x_in      = 18'sd5000;
      tick();
      if (s == 6) check("mrst_lat_before", y_valid, 0);
      if (s == 7) check("mrst_lat_first", y_valid, 1);
    end
    drain();
    check("mrst_count", outq.size(), 20);
    check("mrst_pre", get(9), 0);
    check("mrst_impulse", get(10), 5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
